tt_selftest_harness: RTL and testbench

TT_SELFTEST_HARNESS -- requirements
Module: tt_selftest_harness

---
 rtl/tt_selftest_harness.sv | 113 +++++++++++
 tb/tb_tt_selftest_harness.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_selftest_harness.sv
// tt_selftest_harness: LFSR stimulus generator plus MISR response compactor for DUT self-test.
//   Parameters: IN_W stimulus width, OUT_W response width, NUM_VEC vectors per run,
//               LATENCY DUT response latency, STIM_TAPS / MISR_TAPS feedback masks.
//   Ports: clk, rst (async active-high), start (run request), abort (cancel run),
//          expected (golden signature), stim_out (stimulus to DUT), dut_in (DUT response),
//          busy (RUN/DRAIN), done (DONE), pass (signature matched), signature (MISR value).
//   Optional: define SELFTEST_SEED_LOAD_EN to add input seed[IN_W-1:0], sampled on an
//             accepted start; otherwise the LFSR seed is the constant 1.
module tt_selftest_harness #(
  parameter int IN_W = 8,
  parameter int OUT_W = 8,
  parameter int NUM_VEC = 16,
  parameter int LATENCY = 1,
  parameter logic [IN_W-1:0] STIM_TAPS = IN_W'(8'hB8),
  parameter logic [OUT_W-1:0] MISR_TAPS = OUT_W'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] expected,
`ifdef SELFTEST_SEED_LOAD_EN
  input  logic [IN_W-1:0]  seed,
`endif
  output logic [IN_W-1:0]  stim_out,
  input  logic [OUT_W-1:0] dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int CW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [IN_W-1:0]    r_lfsr;
  logic [OUT_W-1:0]   r_misr;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      r_cap;
  logic [LATENCY-1:0] r_dly;
  logic               r_pass;
  logic               w_start;
  logic               w_run;
  logic               w_cap;
  logic [IN_W-1:0]    w_seed;
  logic [IN_W-1:0]    w_lfsr_next;
  logic [OUT_W-1:0]   w_misr_next;
`ifdef SELFTEST_SEED_LOAD_EN
  // A zero seed would lock the LFSR, so it is promoted to 1.
  assign w_seed = (seed == '0) ? IN_W'(1) : seed;
`else
  assign w_seed = IN_W'(1);
`endif
  assign w_start     = start && !abort && (r_state == S_IDLE || r_state == S_DONE);
  assign w_run       = r_state == S_RUN;
  // The oldest delay-line bit marks the cycle whose dut_in answers a RUN vector.
  assign w_cap       = r_dly[LATENCY-1];
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? STIM_TAPS : '0);
  assign w_misr_next = (r_misr >> 1) ^ (r_misr[0] ? MISR_TAPS : '0) ^ dut_in;
  always_comb begin
    w_state_next = abort ? S_IDLE :
                   w_start ? S_RUN :
                   (w_run && r_cnt == CW'(NUM_VEC - 1)) ? S_DRAIN :
                   (r_state == S_DRAIN && w_cap && r_cap == CW'(NUM_VEC - 1)) ? S_DONE :
                   r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= '0;
      r_misr  <= '0;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_dly   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (abort) begin
        r_dly  <= '0;
        r_cnt  <= '0;
        r_cap  <= '0;
        r_pass <= 1'b0;
      end else if (w_start) begin
        r_lfsr <= w_seed;
        r_misr <= '0;
        r_dly  <= '0;
        r_cnt  <= '0;
        r_cap  <= '0;
        r_pass <= 1'b0;
      end else begin
        r_dly <= (r_dly << 1) | LATENCY'(w_run);
        if (w_run) begin
          r_lfsr <= w_lfsr_next;
          r_cnt  <= r_cnt + 1'b1;
        end
        if (w_cap) begin
          r_misr <= w_misr_next;
          r_cap  <= r_cap + 1'b1;
        end
        // The last capture and the move to DONE share an edge, so compare the incoming value.
        if (r_state == S_DRAIN && w_state_next == S_DONE) r_pass <= (w_misr_next == expected);
      end
    end
  end
  assign stim_out  = w_run ? r_lfsr : '0;
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = r_state == S_DONE;
  assign pass      = r_pass;
  assign signature = r_misr;
endmodule

// File: tb/tb_tt_selftest_harness.sv
// tb_tt_selftest_harness: randomized and directed checks of tt_selftest_harness against a cycle-count model.
module tb_tt_selftest_harness;
  localparam int N = 4;
  localparam int L = 1;
  logic clk = 0;
  logic rst = 1;
  logic start = 0, abort = 0, lb = 1;
  logic [7:0] expected = 0, dut_in = 0, h1 = 0;
  logic [7:0] stim_out, signature;
  logic busy, done, pass;
  logic start3 = 0, abort3 = 0;
  logic [7:0] expected3 = 0, dut_in3 = 0, stim3, sig3;
  logic [7:0] h3 [3] = '{0, 0, 0};
  logic busy3, done3, pass3;
  logic [7:0] seed = 0;
  logic [7:0] got [4];
  int checks = 0, errors = 0;
  bit m_act = 0, m_done = 0, m_pass = 0;
  int m_k = 0;
  logic [7:0] m_sig = 0;
  logic [7:0] m_vec [N];
  always #5 clk = ~clk;
  tt_selftest_harness #(.IN_W(8), .OUT_W(8), .NUM_VEC(N), .LATENCY(L)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
`ifdef SELFTEST_SEED_LOAD_EN
    .seed(seed),
`endif
    .stim_out(stim_out), .dut_in(dut_in), .busy(busy), .done(done), .pass(pass), .signature(signature));
  tt_selftest_harness #(.IN_W(8), .OUT_W(8), .NUM_VEC(4), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .expected(expected3),
`ifdef SELFTEST_SEED_LOAD_EN
    .seed(seed),
`endif
    .stim_out(stim3), .dut_in(dut_in3), .busy(busy3), .done(done3), .pass(pass3), .signature(sig3));
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  // DUT emulation: a register pipeline (or random data) feeding the response ports.
  initial forever begin
    @(negedge clk);
    dut_in = lb ? h1 : 8'($urandom);
    h1 = stim_out;
    dut_in3 = h3[2];
    h3[2] = h3[1];
    h3[1] = h3[0];
    h3[0] = stim3;
  end
  // Model: m_k counts cycles since an accepted start; RUN is 1..N, captures at L+1..N+L.
  initial forever begin
    logic [7:0] v;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_act = 0; m_done = 0; m_pass = 0; m_sig = 0; m_k = 0;
    end else if (abort) begin
      m_act = 0; m_done = 0; m_pass = 0;
    end else if (start && !m_act) begin
`ifdef SELFTEST_SEED_LOAD_EN
      v = (seed == 0) ? 8'd1 : seed;
`else
      v = 8'd1;
`endif
      for (int i = 0; i < N; i++) begin
        m_vec[i] = v;
        v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
      end
      m_act = 1; m_done = 0; m_pass = 0; m_sig = 0; m_k = 1;
    end else if (m_act) begin
      if (m_k > L) m_sig = ((m_sig >> 1) ^ (m_sig[0] ? 8'hB8 : 8'h00)) ^ dut_in;
      if (m_k == N + L) begin
        m_act = 0; m_done = 1; m_pass = (m_sig == expected);
      end else m_k++;
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      chk("m_stim", stim_out, (m_act && m_k <= N) ? m_vec[m_k-1] : 8'h00);
      chk("m_busy", busy, m_act);
      chk("m_done", done, m_done);
      chk("m_pass", pass, m_pass);
      chk("m_sig", signature, m_sig);
    end
  end
  task automatic do_run(input logic [7:0] e, output int d_at, output int b_cnt);
    expected = e;
    start = 1;
    d_at = -1;
    b_cnt = 0;
    for (int k = 1; k <= 20 && d_at < 0; k++) begin
      @(negedge clk);
      start = 0;
      if (busy) b_cnt++;
      if (k <= 4) got[k-1] = stim_out;
      if (done) d_at = k;
    end
  endtask
  task automatic check_loop_run(input string tag);
    int d, b;
    do_run(8'h00, d, b);
    chk({tag, "_stim0"}, got[0], 8'h01);
    chk({tag, "_stim1"}, got[1], 8'hB8);
    chk({tag, "_stim2"}, got[2], 8'h5C);
    chk({tag, "_stim3"}, got[3], 8'h2E);
    chk({tag, "_done_at"}, d, 6);
    chk({tag, "_busy_cnt"}, b, 5);
    chk({tag, "_sig"}, signature, 8'h00);
    chk({tag, "_pass"}, pass, 1);
  endtask
  initial begin
    int d, b;
    repeat (2) @(negedge clk);
    chk("rst_stim", stim_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sig", signature, 0);
    rst = 0;
    @(negedge clk);
    check_loop_run("loop");
    do_run(8'h01, d, b);
    chk("bad_done_at", d, 6);
    chk("bad_done", done, 1);
    chk("bad_pass", pass, 0);
    chk("bad_sig", signature, 8'h00);
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_stim", stim_out, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    chk("abort_norestart", busy, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("drain_busy", busy, 1);
    chk("drain_sig_partial", signature, 8'h5C);
    #1 rst = 1;
    #1;
    chk("arst_stim", stim_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_sig", signature, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("arst_no_partial", {busy, done, pass}, 3'b000);
    check_loop_run("rerun");
    start3 = 1;
    d = -1;
    b = 0;
    for (int k = 1; k <= 20 && d < 0; k++) begin
      @(negedge clk);
      start3 = 0;
      if (busy3) b++;
      if (done3) d = k;
    end
    chk("lat3_busy_cnt", b, 7);
    chk("lat3_done_at", d, 8);
    chk("lat3_sig", sig3, 8'h00);
    chk("lat3_pass", pass3, 1);
`ifdef SELFTEST_SEED_LOAD_EN
    seed = 8'h00;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("seed0_stim", stim_out, 8'h01);
    abort = 1;
    @(negedge clk);
    abort = 0;
    seed = 8'h5C;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("seed5c_stim0", stim_out, 8'h5C);
    @(negedge clk);
    chk("seed5c_stim1", stim_out, 8'h2E);
    @(negedge clk);
    chk("seed5c_stim2", stim_out, 8'h17);
    abort = 1;
    @(negedge clk);
    abort = 0;
`endif
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 50 == 0) lb = 1'($urandom);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 499) == 0);
      if (start) expected = lb ? 8'h00 : 8'($urandom);
`ifdef SELFTEST_SEED_LOAD_EN
      seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
`endif
    end
    @(negedge clk);
    rst = 0;
    start = 0;
    abort = 0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
